// File: rtl/scope_trigger_capture_pkg.sv
// Shared types and defaults for the scope capture stage and its synchroniser bench.
// Latency: n/a (types only).
// Backpressure: n/a.
package scope_pkg;

  localparam int DATA_W = 12;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT,
    POST,
    DONE
  } state_e;

  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

endpackage

// File: rtl/scope_trigger_capture_sample_ram.sv
// Capture buffer: one write port, one registered read port, old data on same-address collision.
// Latency: read data appears one clk after rd_addr; writes land on the same edge.
// Backpressure: none; a write is accepted on every cycle wr_en is high.
// Ports: clk/reset (sync, active-high, clears only the read register), wr_en/wr_addr/wr_data,
//        rd_addr in, rd_data out.
module scope_sample_ram
  import scope_pkg::*;
#(
  parameter int DW = scope_pkg::DATA_W,
  parameter int DP = scope_pkg::DEPTH,
  parameter int AW = scope_pkg::ADDR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DP];
  logic [DW-1:0] rd_data_d;
  logic [DW-1:0] rd_data_q;

  // Contents are never cleared; reset only affects the output register.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Array read happens before the same-edge write commits, giving old data on collision.
  always_comb begin
    rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/scope_trigger_capture.sv
// Level/slope triggered frame capture into a circular buffer with programmable pre-trigger depth.
// Latency: trigger/done flags update on the edge consuming the sample; rd_data one clk after rd_addr.
// Backpressure: none; every sample_valid cycle in PRE/WAIT/POST is consumed.
// Ports: slow_clk/reset (sync, active-high); sample_valid/sample stream in; arm, trig_level,
//        trig_slope, pretrig, force_trig control; rd_addr/rd_data readback; busy, triggered,
//        done, trig_addr, start_addr status.
module scope_trigger_capture
  import scope_pkg::*;
#(
  parameter int DATA_W = scope_pkg::DATA_W,
  parameter int DEPTH  = scope_pkg::DEPTH,
  parameter int ADDR_W = scope_pkg::ADDR_W
) (
  input  logic              slow_clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic              arm,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic              force_trig,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0]   pretrig_q, pretrig_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                prev_valid_q, prev_valid_d;
  logic                force_pend_q, force_pend_d;
  logic                triggered_q, triggered_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0]   start_addr_q, start_addr_d;

  logic                wr_en;
  logic                crossing;
  logic [ADDR_W-1:0]   post_len;

  // Slope crossing between the previous and current sample, unsigned full width.
  always_comb begin
    if (trig_slope == SLOPE_FALL) begin
      crossing = prev_valid_q && (prev_q > trig_level) && (sample <= trig_level);
    end else begin
      crossing = prev_valid_q && (prev_q < trig_level) && (sample >= trig_level);
    end
  end

  // Samples still owed after the trigger sample so the frame totals DEPTH.
  assign post_len = ADDR_W'(DEPTH - 1) - pretrig_q;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    post_cnt_d   = post_cnt_q;
    pretrig_d    = pretrig_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    force_pend_d = force_pend_q;
    triggered_d  = triggered_q;
    done_d       = done_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
    wr_en        = 1'b0;

    if (arm) begin
      // pretrig is ADDR_W bits wide, so it is already bounded by DEPTH-1.
      pretrig_d    = pretrig;
      cnt_d        = '0;
      done_d       = 1'b0;
      triggered_d  = 1'b0;
      prev_valid_d = 1'b0;
      force_pend_d = 1'b0;
      state_d      = (pretrig == '0) ? WAIT : PRE;
    end else begin
      if (sample_valid && (state_q == PRE || state_q == WAIT || state_q == POST)) begin
        wr_en        = 1'b1;
        wr_ptr_d     = wr_ptr_q + ADDR_W'(1);
        prev_d       = sample;
        prev_valid_d = 1'b1;
      end

      case (state_q)
        PRE: begin
          if (sample_valid) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_d == pretrig_q) begin
              state_d = WAIT;
            end
          end
        end
        WAIT: begin
          if (sample_valid && (crossing || force_pend_q)) begin
            triggered_d  = 1'b1;
            trig_addr_d  = wr_ptr_q;
            start_addr_d = wr_ptr_q - pretrig_q;
            force_pend_d = 1'b0;
            post_cnt_d   = post_len;
            if (post_len == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = POST;
            end
          end else if (force_trig) begin
            // A force arriving with a non-triggering sample applies to the next one.
            force_pend_d = 1'b1;
          end
        end
        POST: begin
          if (sample_valid) begin
            post_cnt_d = post_cnt_q - ADDR_W'(1);
            if (post_cnt_q == ADDR_W'(1)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge slow_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      post_cnt_q   <= '0;
      pretrig_q    <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      force_pend_q <= 1'b0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      post_cnt_q   <= post_cnt_d;
      pretrig_q    <= pretrig_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      force_pend_q <= force_pend_d;
      triggered_q  <= triggered_d;
      done_q       <= done_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
    end
  end

  scope_sample_ram #(
    .DW (DATA_W),
    .DP (DEPTH),
    .AW (ADDR_W)
  ) u_ram (
    .clk     (slow_clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (sample),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign busy       = (state_q == PRE) || (state_q == WAIT) || (state_q == POST);
  assign triggered  = triggered_q;
  assign done       = done_q;
  assign trig_addr  = trig_addr_q;
  assign start_addr = start_addr_q;

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Self-checking bench for scope_trigger_capture: directed scenarios plus randomized frames.
// Latency: n/a.
// Backpressure: n/a.
module tb_scope_trigger_capture;

  logic        slow_clk = 1'b0;
  logic        reset, sample_valid, arm, trig_slope, force_trig;
  logic [11:0] sample, trig_level;
  logic [7:0]  pretrig, rd_addr;
  logic [11:0] rd_data;
  logic        busy, triggered, done;
  logic [7:0]  trig_addr, start_addr;

  int checks = 0;
  int failures = 0;

  always #5 slow_clk = ~slow_clk;

  scope_trigger_capture dut (
    .slow_clk     (slow_clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample       (sample),
    .arm          (arm),
    .trig_level   (trig_level),
    .trig_slope   (trig_slope),
    .pretrig      (pretrig),
    .force_trig   (force_trig),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy),
    .triggered    (triggered),
    .done         (done),
    .trig_addr    (trig_addr),
    .start_addr   (start_addr)
  );

  // Reference model: capture phase plus sample counts owed before/after the trigger.
  localparam int P_IDLE = 0, P_PRE = 1, P_WAIT = 2, P_POST = 3, P_DONE = 4;
  logic [11:0] m_mem [256];
  bit          m_known [256];
  int          m_phase = P_IDLE, m_ptr = 0, m_pt = 0, m_pre_left = 0, m_post_left = 0;
  int          m_prev = 0, m_trig_addr = 0, m_start = 0;
  bit          m_prev_ok = 0, m_force = 0, m_trig = 0, m_done = 0, m_rd_known = 0;
  logic [11:0] m_rd = 0;

  function automatic void model_step(bit r, bit a, bit v, int s, bit f);
    int lvl;
    bit hit;
    lvl = int'(trig_level);
    m_rd = m_mem[rd_addr];
    m_rd_known = m_known[rd_addr];
    if (r) begin
      m_phase = P_IDLE; m_trig = 0; m_done = 0; m_trig_addr = 0; m_start = 0;
      m_rd = 0; m_rd_known = 1; m_ptr = 0; m_prev_ok = 0; m_force = 0;
      return;
    end
    if (a) begin
      m_pt = int'(pretrig); m_pre_left = m_pt;
      m_phase = (m_pt == 0) ? P_WAIT : P_PRE;
      m_trig = 0; m_done = 0; m_prev_ok = 0; m_force = 0;
      return;
    end
    if (!v) begin
      if (m_phase == P_WAIT && f) m_force = 1;
      return;
    end
    if (m_phase == P_IDLE || m_phase == P_DONE) return;
    hit = 0;
    if (m_phase == P_WAIT) begin
      if (trig_slope == 1'b0) hit = m_prev_ok && (m_prev < lvl) && (s >= lvl);
      else                    hit = m_prev_ok && (m_prev > lvl) && (s <= lvl);
      hit = hit || m_force;
      if (!hit && f) m_force = 1;
    end
    m_mem[m_ptr] = 12'(s);
    m_known[m_ptr] = 1;
    m_prev = s;
    m_prev_ok = 1;
    if (m_phase == P_PRE) begin
      m_pre_left--;
      if (m_pre_left == 0) m_phase = P_WAIT;
    end else if (m_phase == P_WAIT) begin
      if (hit) begin
        m_trig = 1; m_force = 0;
        m_trig_addr = m_ptr;
        m_start = (m_ptr - m_pt + 256) % 256;
        m_post_left = 255 - m_pt;
        if (m_post_left == 0) begin m_phase = P_DONE; m_done = 1; end
        else m_phase = P_POST;
      end
    end else begin
      m_post_left--;
      if (m_post_left == 0) begin m_phase = P_DONE; m_done = 1; end
    end
    m_ptr = (m_ptr + 1) % 256;
  endfunction

  task automatic cyc(input bit r, input bit a, input bit v, input logic [11:0] s, input bit f);
    reset = r; arm = a; sample_valid = v; sample = s; force_trig = f;
    @(posedge slow_clk);
    model_step(r, a, v, int'(s), f);
    #1;
    reset = 0; arm = 0; sample_valid = 0; force_trig = 0;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 12'h0, 0);
    cyc(1, 0, 0, 12'h0, 0);
    checks++; if (busy !== 0 || triggered !== 0 || done !== 0)
      $display("FAIL reset_flags busy=%0b trig=%0b done=%0b want 0 0 0", busy, triggered, done);
    checks++; if (trig_addr !== 0 || start_addr !== 0)
      $display("FAIL reset_addrs trig_addr=%0h start_addr=%0h want 0 0", trig_addr, start_addr);
    checks++; if (rd_data !== 0) $display("FAIL reset_rd_data got=%0h want 0", rd_data);
    cyc(0, 0, 1, 12'h555, 0);
    checks++; if (busy !== 0 || triggered !== 0)
      $display("FAIL idle_no_capture busy=%0b trig=%0b want 0 0", busy, triggered);
    if (busy !== 0 || triggered !== 0 || trig_addr !== 0 || start_addr !== 0 || rd_data !== 0)
      failures++;
    else if (0) failures++;
  endtask

  task automatic test_rising();
    int base;
    trig_level = 12'h800; trig_slope = 0; pretrig = 8'd4;
    cyc(0, 1, 0, 12'h0, 0);
    base = m_ptr;
    for (int k = 0; k <= 8; k++) begin
      cyc(0, 0, 1, 12'(k * 256), 0);
      if (k == 7) begin
        checks++; if (triggered !== 0) begin failures++; $display("FAIL rise_early got=%0b want 0", triggered); end
      end
    end
    checks++; if (triggered !== 1) begin failures++; $display("FAIL rise_trig got=%0b want 1", triggered); end
    checks++; if (trig_addr !== 8'((base + 8) % 256)) begin
      failures++; $display("FAIL rise_trig_addr got=%0h want %0h", trig_addr, (base + 8) % 256); end
    checks++; if (start_addr !== 8'((base + 4) % 256)) begin
      failures++; $display("FAIL rise_start_addr got=%0h want %0h", start_addr, (base + 4) % 256); end
    for (int k = 9; k < 259; k++) cyc(0, 0, 1, 12'(k * 256), 0);
    checks++; if (done !== 0 || busy !== 1) begin
      failures++; $display("FAIL rise_post_250 done=%0b busy=%0b want 0 1", done, busy); end
    cyc(0, 0, 1, 12'(259 * 256), 0);
    checks++; if (done !== 1 || busy !== 0) begin
      failures++; $display("FAIL rise_done done=%0b busy=%0b want 1 0", done, busy); end
    // A sample in DONE would land on start_addr if it were (wrongly) written.
    cyc(0, 0, 1, 12'hFFF, 0);
    for (int i = 0; i < 12; i++) begin
      rd_addr = 8'((base + 4 + i) % 256);
      cyc(0, 0, 0, 12'h0, 0);
      checks++; if (rd_data !== 12'((4 + i) * 256)) begin
        failures++; $display("FAIL rise_readback[%0d] got=%0h want %0h", i, rd_data, 12'((4 + i) * 256)); end
    end
  endtask

  task automatic test_falling();
    int base;
    trig_level = 12'hAAA; trig_slope = 1; pretrig = 8'd0;
    cyc(0, 1, 0, 12'h0, 0);
    base = m_ptr;
    cyc(0, 0, 1, 12'hEFF, 0);
    cyc(0, 0, 1, 12'hEAE, 0);
    checks++; if (triggered !== 0) begin failures++; $display("FAIL fall_early got=%0b want 0", triggered); end
    cyc(0, 0, 1, 12'hAAA, 0);
    checks++; if (triggered !== 1 || trig_addr !== 8'((base + 2) % 256)) begin
      failures++; $display("FAIL fall_trig trig=%0b addr=%0h want 1 %0h", triggered, trig_addr, (base + 2) % 256); end
    cyc(0, 1, 0, 12'h0, 0);
    for (int k = 0; k < 20; k++) cyc(0, 0, 1, 12'h123, 0);
    checks++; if (busy !== 1 || done !== 0 || triggered !== 0) begin
      failures++; $display("FAIL fall_const busy=%0b done=%0b trig=%0b want 1 0 0", busy, done, triggered); end
  endtask

  task automatic test_pre_mask_force();
    int base;
    logic [11:0] pre_seq [8];
    pre_seq = '{12'h000, 12'h100, 12'h200, 12'h900, 12'h900, 12'h900, 12'h900, 12'h900};
    trig_level = 12'h800; trig_slope = 0; pretrig = 8'd8;
    cyc(0, 1, 0, 12'h0, 0);
    base = m_ptr;
    for (int k = 0; k < 8; k++) cyc(0, 0, 1, pre_seq[k], 0);
    checks++; if (triggered !== 0 || busy !== 1) begin
      failures++; $display("FAIL pre_mask trig=%0b busy=%0b want 0 1", triggered, busy); end
    cyc(0, 0, 1, 12'h900, 0);
    cyc(0, 0, 0, 12'h0, 1);
    cyc(0, 0, 0, 12'h0, 0);
    checks++; if (triggered !== 0) begin failures++; $display("FAIL force_early got=%0b want 0", triggered); end
    cyc(0, 0, 1, 12'h000, 0);
    checks++; if (triggered !== 1 || trig_addr !== 8'((base + 9) % 256)) begin
      failures++; $display("FAIL force_trig trig=%0b addr=%0h want 1 %0h", triggered, trig_addr, (base + 9) % 256); end
  endtask

  task automatic test_boundaries();
    int base;
    trig_level = 12'h800; trig_slope = 0;
    for (int fr = 0; fr < 2; fr++) begin
      pretrig = 8'd255;
      cyc(0, 1, 0, 12'h0, 0);
      base = m_ptr;
      for (int i = 0; i < 255; i++) cyc(0, 0, 1, (i == 254) ? 12'h000 : 12'($urandom_range(0, 4095)), 0);
      checks++; if (busy !== 1 || triggered !== 0) begin
        failures++; $display("FAIL pt255_wait[%0d] busy=%0b trig=%0b want 1 0", fr, busy, triggered); end
      cyc(0, 0, 1, 12'hFFF, 0);
      checks++; if (done !== 1 || triggered !== 1 || busy !== 0) begin
        failures++; $display("FAIL pt255_done[%0d] done=%0b trig=%0b busy=%0b want 1 1 0", fr, done, triggered, busy); end
      checks++; if (trig_addr !== 8'((base + 255) % 256) || start_addr !== 8'(base)) begin
        failures++; $display("FAIL pt255_addrs[%0d] trig=%0h start=%0h want %0h %0h", fr, trig_addr, start_addr,
                             (base + 255) % 256, base); end
    end
    // Re-arm after a low WAIT sample: the stale low sample must not arm a crossing.
    pretrig = 8'd0;
    cyc(0, 1, 0, 12'h0, 0);
    checks++; if (busy !== 1) begin failures++; $display("FAIL pt0_busy got=%0b want 1", busy); end
    cyc(0, 0, 1, 12'h000, 0);
    cyc(0, 1, 0, 12'h0, 0);
    base = m_ptr;
    cyc(0, 0, 1, 12'hFFF, 0);
    checks++; if (triggered !== 0) begin failures++; $display("FAIL pt0_first got=%0b want 0", triggered); end
    cyc(0, 0, 1, 12'h000, 0);
    cyc(0, 0, 1, 12'hFFF, 0);
    checks++; if (triggered !== 1 || trig_addr !== 8'((base + 2) % 256)) begin
      failures++; $display("FAIL pt0_second trig=%0b addr=%0h want 1 %0h", triggered, trig_addr, (base + 2) % 256); end
  endtask

  task automatic test_gapped_collision();
    int base;
    logic [11:0] old_val, new_val;
    trig_level = 12'h800; trig_slope = 0; pretrig = 8'd3;
    cyc(0, 1, 0, 12'h0, 0);
    base = m_ptr;
    for (int i = 0; i < 30; i++) cyc(0, 0, (i % 3) == 0, 12'h100, 0);
    cyc(0, 1, 1, 12'hFFF, 0);
    checks++; if (busy !== 1 || triggered !== 0 || done !== 0) begin
      failures++; $display("FAIL rearm_flags busy=%0b trig=%0b done=%0b want 1 0 0", busy, triggered, done); end
    for (int i = 0; i < 12; i++) cyc(0, 0, (i % 3) == 0, 12'h100, 0);
    cyc(0, 0, 1, 12'hFFF, 0);
    checks++; if (triggered !== 1 || trig_addr !== 8'((base + 14) % 256)) begin
      failures++; $display("FAIL gapped_trig trig=%0b addr=%0h want 1 %0h", triggered, trig_addr, (base + 14) % 256); end
    rd_addr = 8'((base + 15) % 256);
    old_val = m_mem[rd_addr];
    new_val = ~old_val;
    cyc(0, 0, 1, new_val, 0);
    checks++; if (rd_data !== old_val) begin
      failures++; $display("FAIL collision_old got=%0h want %0h", rd_data, old_val); end
    cyc(0, 0, 0, 12'h0, 0);
    checks++; if (rd_data !== new_val) begin
      failures++; $display("FAIL collision_new got=%0h want %0h", rd_data, new_val); end
  endtask

  task automatic test_reset_mid_post();
    trig_level = 12'h800; trig_slope = 0; pretrig = 8'd4;
    cyc(0, 1, 0, 12'h0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 12'h100, 0);
    cyc(0, 0, 1, 12'h000, 0);
    cyc(0, 0, 1, 12'hFFF, 0);
    for (int k = 0; k < 10; k++) cyc(0, 0, 1, 12'h321, 0);
    checks++; if (busy !== 1 || triggered !== 1) begin
      failures++; $display("FAIL post_pre_reset busy=%0b trig=%0b want 1 1", busy, triggered); end
    cyc(1, 1, 1, 12'h0, 0);
    checks++; if (busy !== 0 || triggered !== 0 || done !== 0 || trig_addr !== 0 || start_addr !== 0 || rd_data !== 0) begin
      failures++; $display("FAIL post_reset busy=%0b trig=%0b done=%0b ta=%0h sa=%0h rd=%0h want all 0",
                           busy, triggered, done, trig_addr, start_addr, rd_data); end
    pretrig = 8'd0;
    cyc(0, 1, 0, 12'h0, 0);
    cyc(0, 0, 1, 12'h000, 0);
    cyc(0, 0, 1, 12'hFFF, 0);
    checks++; if (triggered !== 1 || trig_addr !== 8'd1 || start_addr !== 8'd1) begin
      failures++; $display("FAIL post_reset_recap trig=%0b ta=%0h sa=%0h want 1 1 1", triggered, trig_addr, start_addr); end
    for (int k = 0; k < 255; k++) cyc(0, 0, 1, 12'h444, 0);
    checks++; if (done !== 1) begin failures++; $display("FAIL post_reset_done got=%0b want 1", done); end
  endtask

  task automatic test_random();
    bit v, f, a, exp_busy;
    for (int fr = 0; fr < 6; fr++) begin
      trig_level = 12'($urandom_range(0, 4095));
      trig_slope = 1'($urandom_range(0, 1));
      pretrig = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 30));
      cyc(0, 1, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)), 0);
      for (int cy = 0; cy < 3000 && !m_done; cy++) begin
        rd_addr = 8'($urandom_range(0, 255));
        v = $urandom_range(0, 9) < 7;
        f = $urandom_range(0, 49) == 0;
        a = (cy < 100) && ($urandom_range(0, 59) == 0);
        cyc(0, a, v, 12'($urandom_range(0, 4095)), f);
        exp_busy = (m_phase == P_PRE) || (m_phase == P_WAIT) || (m_phase == P_POST);
        checks++; if (busy !== exp_busy || triggered !== m_trig || done !== m_done) begin
          failures++; $display("FAIL rand_flags[%0d/%0d] busy=%0b trig=%0b done=%0b want %0b %0b %0b",
                               fr, cy, busy, triggered, done, exp_busy, m_trig, m_done); end
        if (m_rd_known) begin
          checks++; if (rd_data !== m_rd) begin
            failures++; $display("FAIL rand_rd[%0d/%0d] got=%0h want %0h", fr, cy, rd_data, m_rd); end
        end
      end
      checks++; if (!m_done) begin failures++; $display("FAIL rand_timeout[%0d] frame not complete", fr); end
      checks++; if (trig_addr !== 8'(m_trig_addr) || start_addr !== 8'(m_start)) begin
        failures++; $display("FAIL rand_addrs[%0d] ta=%0h sa=%0h want %0h %0h", fr, trig_addr, start_addr,
                             m_trig_addr, m_start); end
    end
  endtask

  initial begin
    reset = 1; arm = 0; sample_valid = 0; sample = 0; force_trig = 0;
    trig_level = 0; trig_slope = 0; pretrig = 0; rd_addr = 0;
    test_reset();
    test_rising();
    test_falling();
    test_pre_mask_force();
    test_boundaries();
    test_gapped_collision();
    test_reset_mid_post();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scope_trigger_capture.md
Name: scope_trigger_capture

Overview:
- Slow-domain stage directly downstream of the fast-to-slow sample synchroniser; consumes the 12-bit synchronised ADC word.
- Performs level/slope trigger detection with a programmable pre-trigger depth and captures one frame into an on-chip circular buffer.
- Exposes a registered read port and status flags to the Nios II display/readout logic.

Parameters:
- DATA_W, 12, sample width (matches synchroniser output).
- DEPTH, 256, frame length in samples; power of two.
- ADDR_W, 8, log2(DEPTH).

Ports:
- slow_clk  in  1  sole clock, slow domain.
- reset  in  1  synchronous, active-high.
- sample_valid  in  1  sample strobe; one sample consumed per high cycle.
- sample  in  DATA_W  synchronised sample, unsigned.
- arm  in  1  one-cycle pulse; starts or restarts a capture.
- trig_level  in  DATA_W  trigger threshold, unsigned.
- trig_slope  in  1  0 = rising, 1 = falling.
- pretrig  in  ADDR_W  samples kept before the trigger sample; sampled on arm.
- force_trig  in  1  pulse; treat the next valid sample in WAIT as the trigger sample.
- rd_addr  in  ADDR_W  buffer read address, absolute.
- rd_data  out  DATA_W  buffer[rd_addr], registered.
- busy  out  1  high in PRE, WAIT and POST.
- triggered  out  1  high from trigger capture until the next arm or reset.
- done  out  1  frame complete; held until arm or reset.
- trig_addr  out  ADDR_W  buffer address of the trigger sample.
- start_addr  out  ADDR_W  oldest frame sample, (trig_addr - pretrig_q) mod DEPTH.

Behaviour:
- Reset (slow_clk edge with reset = 1):
  - State IDLE; busy, triggered, done, trig_addr, start_addr, rd_data = 0; wr_ptr = 0; prev_valid = 0; force_pend = 0.
  - Buffer contents are not cleared.
  - Reset has priority over arm, including mid-capture.
- States:
  - IDLE: nothing written. arm -> PRE.
  - PRE: each valid sample is written at wr_ptr, wr_ptr++, cnt++. When cnt == pretrig_q -> WAIT (same edge as the final pre sample). pretrig_q = 0 enters WAIT immediately after arm. Triggers and force_trig are ignored.
  - WAIT: every valid sample is written. If it meets the trigger condition or force_pend is set: trig_addr = wr_ptr, triggered = 1, post_cnt = DEPTH-1-pretrig_q, force_pend cleared -> POST. post_cnt = 0 goes directly to DONE.
  - POST: each valid sample is written and post_cnt decrements. The edge writing the last sample -> DONE, done = 1, busy = 0.
  - DONE: no writes; hold until arm.
- On arm:
  - Latch pretrig_q = min(pretrig, DEPTH-1); clear cnt, done, triggered, prev_valid, force_pend.
  - wr_ptr is not reset; wraps mod DEPTH.
  - An arm in PRE, WAIT or POST restarts into PRE the next cycle.
  - An arm coinciding with sample_valid does not write that sample.
- Trigger condition, requires prev_valid:
  - Rising: prev < trig_level and sample >= trig_level.
  - Falling: prev > trig_level and sample <= trig_level.
  - prev/prev_valid update on every valid sample in PRE, WAIT and POST, so the first sample after arm can never trigger.
- force_trig: sets force_pend when asserted in WAIT; ignored in other states.
- sample_valid low: no state, counter or pointer change.
- Read port:
  - rd_data = buffer[rd_addr] one cycle later, in any state.
  - A read and write to the same address on the same edge returns the old data.
- Comparisons are unsigned, full DATA_W width. Counters are ADDR_W wide and never overflow, given the clamp.

Decomposition:
- Package scope_pkg holds the state enum (IDLE, PRE, WAIT, POST, DONE), the slope encodings (SLOPE_RISE = 0, SLOPE_FALL = 1) and DATA_W/DEPTH defaults shared with the synchroniser bench.
- One sub-module, scope_sample_ram: simple dual-port RAM, one write port and one registered read port, old-data on collision. FSM, counters and trigger compare stay in the top.

Test Plan:
- Reset mid-POST (arm, trigger, assert reset after 10 post samples) -> next cycle busy = triggered = done = 0, state IDLE; a later arm captures normally.
- Rising trigger: pretrig = 4, trig_level = 12'h800, ramp 12'h000 +12'h100 per valid sample -> trigger on the 12'h800 sample, trig_addr = wr_ptr at that sample, start_addr = trig_addr - 4, done after 251 further samples; readback from start_addr gives a contiguous ramp.
- Falling slope: trig_slope = 1, level 12'hAAA, sequence 12'hEFF, 12'hEAE, 12'hAAA -> trigger on the 12'hAAA sample. A constant 12'h123 sequence -> stays in WAIT, busy = 1, done = 0.
- PRE masking: pretrig = 8 with a crossing at sample 3 -> no trigger. force_trig pulsed in WAIT -> the next valid sample becomes the trigger sample.
- Boundaries:
  - pretrig = 255 -> post_cnt = 0; done on the trigger edge.
  - pretrig = 0 -> first eligible sample is the second after arm.
  - wr_ptr wraps 255 -> 0 correctly across back-to-back arms.
- Gapped sample_valid (1 in 3) plus arm re-pulsed during WAIT -> no writes on invalid cycles; re-arm restarts PRE with cleared flags; a rd_addr == write address collision returns old data.
